// File: rtl/sqrt_fixed_point_seq.sv
// Iterative restoring square root, one root bit per clock, with valid/ready
// handshakes on both sides. The radical is aligned into a 2*outputWidth word first.
module sqrt_fixed_point_seq #(
  parameter int inputWidth    = 8,
  parameter int inputDecWidth = 8,
  parameter int outputWidth   = inputWidth
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [inputWidth-1:0]  radical,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [outputWidth-1:0] q,
  output logic [outputWidth:0]   remainder,
  output logic                   busy
);

  localparam int WI  = inputWidth - inputDecWidth;
  localparam int ODD = WI & 1;
  localparam int PW  = 2 * outputWidth;
  localparam int PAD = PW - inputWidth - ODD;
  localparam int RW  = outputWidth + 2;
  localparam int CW  = (outputWidth > 1) ? $clog2(outputWidth) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, next_state;
  logic [PW-1:0]          p_sh;
  logic [outputWidth-1:0] root, root_next;
  logic [RW-1:0]          rem, rem_shift, rem_next, trial;
  logic [CW-1:0]          cnt;
  logic                   accept, take;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: if (cnt == '0) next_state = DONE;
      DONE: begin
        if (out_ready) begin
          in_ready   = 1'b1;
          next_state = in_valid ? BUSY : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  // The aligned radical is shifted left two bits per step, so the pair
  // consumed in each iteration is always the top two bits.
  always_comb begin
    rem_shift = (rem << 2) | RW'(p_sh[PW-1 -: 2]);
    trial     = {root, 2'b01};
    take      = (rem_shift >= trial);
    rem_next  = take ? (rem_shift - trial) : rem_shift;
    root_next = (root << 1) | outputWidth'(take);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      p_sh      <= '0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
      q         <= '0;
      remainder <= '0;
    end else if (accept) begin
      p_sh <= PW'(radical) << PAD;
      root <= '0;
      rem  <= '0;
      cnt  <= CW'(outputWidth - 1);
    end else if (state == BUSY) begin
      p_sh <= p_sh << 2;
      root <= root_next;
      rem  <= rem_next;
      cnt  <= cnt - CW'(1);
      if (cnt == '0) begin
        q         <= root_next;
        remainder <= rem_next[outputWidth:0];
      end
    end
  end

endmodule

// File: tb/tb_sqrt_fixed_point_seq.sv
// Self-checking bench for sqrt_fixed_point_seq: directed corner cases plus a
// randomized handshake run scored against a floor-sqrt search model.
module tb_sqrt_fixed_point_seq;

  int tests = 0;
  int fails = 0;

  logic       clk = 1'b0;
  logic       aclr_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] radical = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] q;
  logic [8:0] remainder;

  logic       iv4 = 1'b0, iv5 = 1'b0, one = 1'b1;
  logic [7:0] rad4 = '0, rad5 = '0;
  logic       ir4, ir5, ov4, ov5, busy4, busy5;
  logic [7:0] q4, q5;
  logic [8:0] rem4, rem5;

  always #5 clk = ~clk;

  sqrt_fixed_point_seq dut (
    .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready),
    .radical(radical), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .remainder(remainder), .busy(busy));

  sqrt_fixed_point_seq #(.inputWidth(8), .inputDecWidth(4)) dut4 (
    .clk(clk), .aclr_n(aclr_n), .in_valid(iv4), .in_ready(ir4),
    .radical(rad4), .out_valid(ov4), .out_ready(one),
    .q(q4), .remainder(rem4), .busy(busy4));

  sqrt_fixed_point_seq #(.inputWidth(8), .inputDecWidth(5)) dut5 (
    .clk(clk), .aclr_n(aclr_n), .in_valid(iv5), .in_ready(ir5),
    .radical(rad5), .out_valid(ov5), .out_ready(one),
    .q(q5), .remainder(rem5), .busy(busy5));

  // Reference: align the radical arithmetically, then search for floor(sqrt).
  function automatic void model(input int idw, input logic [7:0] rad,
                                output longint p, output longint rq, output longint rr);
    int odd;
    int pad;
    odd = (8 - idw) & 1;
    pad = 16 - 8 - odd;
    p   = longint'(rad) * (longint'(1) << pad);
    rq  = 0;
    while ((rq + 1) * (rq + 1) <= p) rq++;
    rr = p - rq * rq;
  endfunction

  task automatic run_one(input logic [7:0] rad, input logic [7:0] exp_q,
                         input logic [8:0] exp_r, input string name);
    int k;
    @(negedge clk);
    radical = rad; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k !== 8) begin
      fails++;
      $display("FAIL %s_latency: got %0d edges, expected 8", name, k);
    end
    tests++;
    if (q !== exp_q || remainder !== exp_r) begin
      fails++;
      $display("FAIL %s_result: got q=%h rem=%h, expected q=%h rem=%h",
               name, q, remainder, exp_q, exp_r);
    end
  endtask

  task automatic test_reset();
    aclr_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || q !== 8'h00 || remainder !== 9'h000
        || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got ov=%b busy=%b q=%h rem=%h ir=%b, expected 0 0 00 000 1",
               out_valid, busy, q, remainder, in_ready);
    end
  endtask

  // Release reset and accept on the very first edge afterwards.
  task automatic test_first_accept();
    int k;
    @(negedge clk);
    aclr_n = 1'b1; radical = 8'h40; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_accept_busy: got busy=%b ov=%b, expected 1 0", busy, out_valid);
    end
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k !== 8) begin
      fails++;
      $display("FAIL quarter_latency: got %0d edges, expected 8", k);
    end
    tests++;
    if (q !== 8'h80 || remainder !== 9'h000) begin
      fails++;
      $display("FAIL quarter_result: got q=%h rem=%h, expected q=80 rem=000", q, remainder);
    end
  endtask

  task automatic test_extremes();
    run_one(8'hFF, 8'hFF, 9'h0FF, "max");
    run_one(8'h00, 8'h00, 9'h000, "zero");
  endtask

  task automatic test_alignment();
    int k;
    @(negedge clk);
    rad4 = 8'h90; iv4 = 1'b1;
    rad5 = 8'h80; iv5 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0; iv5 = 1'b0;
    k = 0;
    while (!(ov4 && ov5) && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k !== 8) begin
      fails++;
      $display("FAIL align_latency: got %0d edges, expected 8", k);
    end
    tests++;
    if (q4 !== 8'hC0 || rem4 !== 9'h000) begin
      fails++;
      $display("FAIL align_even_wi: got q=%h rem=%h, expected q=c0 rem=000", q4, rem4);
    end
    tests++;
    if (q5 !== 8'h80 || rem5 !== 9'h000) begin
      fails++;
      $display("FAIL align_odd_wi: got q=%h rem=%h, expected q=80 rem=000", q5, rem5);
    end
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk);
    radical = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k !== 8) begin
      fails++;
      $display("FAIL stall_latency: got %0d edges, expected 8", k);
    end
    radical = 8'h00; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0
          || q !== 8'hFF || remainder !== 9'h0FF) begin
        fails++;
        $display("FAIL stall_hold: got ov=%b ir=%b busy=%b q=%h rem=%h, expected 1 0 0 ff 0ff",
                 out_valid, in_ready, busy, q, remainder);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready: got in_ready=%b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: got ov=%b busy=%b, expected 0 1", out_valid, busy);
    end
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k !== 8) begin
      fails++;
      $display("FAIL b2b_latency: got %0d edges, expected 8", k);
    end
    tests++;
    if (q !== 8'h00 || remainder !== 9'h000) begin
      fails++;
      $display("FAIL b2b_result: got q=%h rem=%h, expected q=00 rem=000", q, remainder);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit spurious;
    run_one(8'hFF, 8'hFF, 9'h0FF, "pre_reset");
    @(negedge clk);
    radical = 8'h40; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    aclr_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || q !== 8'h00 || remainder !== 9'h000
        || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: got ov=%b busy=%b q=%h rem=%h ir=%b, expected 0 0 00 000 1",
               out_valid, busy, q, remainder, in_ready);
    end
    @(negedge clk);
    aclr_n = 1'b1;
    spurious = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    tests++;
    if (spurious) begin
      fails++;
      $display("FAIL post_reset_quiet: got spurious activity=1, expected 0");
    end
    run_one(8'h40, 8'h80, 9'h000, "post_reset");
  endtask

  task automatic test_random();
    logic [7:0] pending[$];
    logic [7:0] r;
    longint     p, mq, mr;
    int         sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    while ((sent < 1200 || pending.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (sent < 1200) begin
        in_valid = ($urandom_range(0, 9) < 7);
        radical  = 8'($urandom);
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        if (pending.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rand_duplicate: got q=%h with nothing outstanding, expected no result", q);
        end else begin
          r = pending.pop_front();
          model(8, r, p, mq, mr);
          got++;
          tests++;
          if (longint'(q) !== mq || longint'(remainder) !== mr) begin
            fails++;
            $display("FAIL rand_result: radical=%h got q=%h rem=%h, expected q=%0h rem=%0h",
                     r, q, remainder, mq, mr);
          end
        end
      end
      if (in_valid && in_ready) begin
        pending.push_back(radical);
        sent++;
      end
    end
    tests++;
    if (sent !== 1200 || got !== 1200 || pending.size() !== 0) begin
      fails++;
      $display("FAIL rand_count: got sent=%0d received=%0d outstanding=%0d, expected 1200 1200 0",
               sent, got, pending.size());
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_extremes();
    test_alignment();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
